// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and GF(2^8) helpers.
package aes_pkg;

    localparam int IDX_W = 4;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] block_t;
    typedef byte_t        bytes_t [16];

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } fsm_e;

    function automatic byte_t rcon(input logic [IDX_W-1:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t acc;
        byte_t x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            else      acc = acc;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Byte 0 is the most significant byte of the block.
    function automatic byte_t get_byte(input block_t blk, input logic [IDX_W-1:0] idx);
        return blk[8*(15 - int'(idx)) +: 8];
    endfunction

    function automatic block_t set_byte(input block_t blk, input logic [IDX_W-1:0] idx,
                                        input byte_t val);
        block_t r;
        r = blk;
        r[8*(15 - int'(idx)) +: 8] = val;
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: tower-field inversion (norm a^17 lies in the GF(2^4)
// subfield, is inverted there as n^14 and scales the conjugate a^16), then affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    byte_t a16_s, norm_s, n2_s, n4_s, n8_s, norm_inv_s, inv_s;

    // Inversion through the GF(2^4) subfield followed by the affine transform.
    always_comb begin
        a16_s      = gf_mul(a_i, a_i);
        a16_s      = gf_mul(a16_s, a16_s);
        a16_s      = gf_mul(a16_s, a16_s);
        a16_s      = gf_mul(a16_s, a16_s);
        norm_s     = gf_mul(a_i, a16_s);
        n2_s       = gf_mul(norm_s, norm_s);
        n4_s       = gf_mul(n2_s, n2_s);
        n8_s       = gf_mul(n4_s, n4_s);
        norm_inv_s = gf_mul(gf_mul(n2_s, n4_s), n8_s);
        inv_s      = gf_mul(a16_s, norm_inv_s);
        s_o        = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
                   ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/tt_um_bah_aes_encrypt.sv
// Byte-serial AES-128 encryptor for Tiny Tapeout: one full round per clock.
module tt_um_bah_aes_encrypt
    import aes_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    fsm_e             fsm_q, fsm_d;
    block_t           key_q, key_d, pt_q, pt_d, state_q, state_d, rk_q, rk_d, ct_q, ct_d;
    logic [IDX_W-1:0] kidx_q, kidx_d, pidx_q, pidx_d, ridx_q, ridx_d, round_q, round_d;
    logic             done_q, done_d;
    logic             busy_s, last_s;
    logic             wr_s, sel_s, start_s, rd_s, unused_s;
    bytes_t           sb_s, sr_s, mc_s;
    byte_t            ks_s [4];
    logic [31:0]      temp_s, w0_s, w1_s, w2_s, w3_s;
    block_t           rk_nxt_s, rnd_s;

    assign wr_s     = uio_in[0];
    assign sel_s    = uio_in[1];
    assign start_s  = uio_in[2];
    assign rd_s     = uio_in[3];
    assign unused_s = &{1'b0, ena, uio_in[7:4]};

    for (genvar gi = 0; gi < 16; gi++) begin : g_state_sbox
        aes_sbox u_sbox (.a_i(state_q[8*(15-gi) +: 8]), .s_o(sb_s[gi]));
    end

    // SubWord(RotWord(w3)): last word bytes 13,14,15,12.
    for (genvar gk = 0; gk < 4; gk++) begin : g_key_sbox
        aes_sbox u_sbox (.a_i(rk_q[8*(3-((gk+1)%4)) +: 8]), .s_o(ks_s[gk]));
    end

    // ShiftRows and MixColumns on the column-major state.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sr_s[i] = sb_s[(i%4) + 4*(((i/4) + (i%4)) % 4)];
        end
        for (int c = 0; c < 4; c++) begin
            mc_s[4*c]   = xtime(sr_s[4*c]) ^ xtime(sr_s[4*c+1]) ^ sr_s[4*c+1]
                        ^ sr_s[4*c+2] ^ sr_s[4*c+3];
            mc_s[4*c+1] = sr_s[4*c] ^ xtime(sr_s[4*c+1]) ^ xtime(sr_s[4*c+2])
                        ^ sr_s[4*c+2] ^ sr_s[4*c+3];
            mc_s[4*c+2] = sr_s[4*c] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2])
                        ^ xtime(sr_s[4*c+3]) ^ sr_s[4*c+3];
            mc_s[4*c+3] = xtime(sr_s[4*c]) ^ sr_s[4*c] ^ sr_s[4*c+1]
                        ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
        end
    end

    // Next round key and AddRoundKey, skipping MixColumns in the final round.
    always_comb begin
        last_s   = (round_q == 4'd10);
        temp_s   = {ks_s[0] ^ rcon(round_q), ks_s[1], ks_s[2], ks_s[3]};
        w0_s     = rk_q[127:96] ^ temp_s;
        w1_s     = rk_q[95:64]  ^ w0_s;
        w2_s     = rk_q[63:32]  ^ w1_s;
        w3_s     = rk_q[31:0]   ^ w2_s;
        rk_nxt_s = {w0_s, w1_s, w2_s, w3_s};
        rnd_s    = 128'h0;
        for (int i = 0; i < 16; i++) begin
            rnd_s[8*(15-i) +: 8] = (last_s ? sr_s[i] : mc_s[i]) ^ rk_nxt_s[8*(15-i) +: 8];
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= S_IDLE;
        else        fsm_q <= fsm_d;
    end

    // Control next state.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  fsm_d = start_s ? S_BUSY : S_IDLE;
            S_BUSY:  fsm_d = last_s  ? S_IDLE : S_BUSY;
            default: fsm_d = S_IDLE;
        endcase
    end

    // Control outputs.
    always_comb begin
        busy_s = (fsm_q == S_BUSY);
    end

    // Load, start, round and readout datapath next state.
    always_comb begin
        key_d   = key_q;
        pt_d    = pt_q;
        state_d = state_q;
        rk_d    = rk_q;
        ct_d    = ct_q;
        kidx_d  = kidx_q;
        pidx_d  = pidx_q;
        ridx_d  = ridx_q;
        round_d = round_q;
        done_d  = done_q;
        if (!busy_s) begin
            if (wr_s && sel_s) begin
                pt_d   = set_byte(pt_q, pidx_q, ui_in);
                pidx_d = pidx_q + 4'd1;
                done_d = 1'b0;
            end else if (wr_s) begin
                key_d  = set_byte(key_q, kidx_q, ui_in);
                kidx_d = kidx_q + 4'd1;
                done_d = 1'b0;
            end else begin
                done_d = done_q;
            end
            if (rd_s) ridx_d = ridx_q + 4'd1;
            else      ridx_d = ridx_q;
            // Start samples the registers as they were before any same-cycle write.
            if (start_s) begin
                state_d = pt_q ^ key_q;
                rk_d    = key_q;
                round_d = 4'd1;
                done_d  = 1'b0;
                kidx_d  = 4'd0;
                pidx_d  = 4'd0;
            end else begin
                round_d = round_q;
            end
        end else begin
            state_d = rnd_s;
            rk_d    = rk_nxt_s;
            round_d = round_q + 4'd1;
            if (last_s) begin
                ct_d    = rnd_s;
                done_d  = 1'b1;
                ridx_d  = 4'd0;
                round_d = 4'd0;
            end else begin
                ct_d    = ct_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= 128'h0;
            pt_q    <= 128'h0;
            state_q <= 128'h0;
            rk_q    <= 128'h0;
            ct_q    <= 128'h0;
            kidx_q  <= 4'd0;
            pidx_q  <= 4'd0;
            ridx_q  <= 4'd0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            pt_q    <= pt_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            ct_q    <= ct_d;
            kidx_q  <= kidx_d;
            pidx_q  <= pidx_d;
            ridx_q  <= ridx_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign uo_out  = get_byte(ct_q, ridx_q);
    assign uio_out = {2'b00, done_q, busy_s, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_bah_aes_encrypt.sv
// Randomized bench with an in-bench AES-128 and pin-level interface model.
module tb_tt_um_bah_aes_encrypt;

    logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
    logic       ena, clk, rst_n;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    logic [7:0] sbox_t [256];

    logic [127:0] m_key, m_pt, m_ct, m_pend;
    int           m_kidx, m_pidx, m_ridx, m_cnt;
    bit           m_busy, m_done;

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    tt_um_bah_aes_encrypt dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] blk_byte(input logic [127:0] b, input int i);
        return b[127 - 8*i -: 8];
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tw [4];
        logic [7:0]   rc;
        logic [127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = blk_byte(k, i);
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tw[j] = w[i-4+j];
            if (i % 16 == 0) begin
                tw = '{sbox_t[w[i-3]] ^ rc, sbox_t[w[i-2]], sbox_t[w[i-1]], sbox_t[w[i-4]]};
                rc = bmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tw[j];
        end
        for (int i = 0; i < 16; i++) s[i] = blk_byte(p, i) ^ w[i];
        for (int rn = 1; rn <= 10; rn++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            if (rn != 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = bmul(8'h02, t[4*c]) ^ bmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ bmul(8'h02, t[4*c+1]) ^ bmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ bmul(8'h02, t[4*c+2]) ^ bmul(8'h03, t[4*c+3]);
                    s[4*c+3] = bmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ bmul(8'h02, t[4*c+3]);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rn + i];
        end
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic model_reset();
        m_key = '0; m_pt = '0; m_ct = '0; m_pend = '0;
        m_kidx = 0; m_pidx = 0; m_ridx = 0; m_cnt = 0;
        m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic sel, input logic st,
                              input logic rd, input logic [7:0] d);
        if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_ct = m_pend; m_ridx = 0;
            end
        end else begin
            if (st) m_pend = aes_enc(m_key, m_pt);
            if (wr) begin
                if (sel) begin m_pt[127 - 8*m_pidx -: 8] = d;  m_pidx = (m_pidx + 1) % 16; end
                else     begin m_key[127 - 8*m_kidx -: 8] = d; m_kidx = (m_kidx + 1) % 16; end
                m_done = 1'b0;
            end
            if (rd) m_ridx = (m_ridx + 1) % 16;
            if (st) begin
                m_busy = 1'b1; m_done = 1'b0; m_cnt = 10; m_kidx = 0; m_pidx = 0;
            end
        end
    endtask

    task automatic cyc(input logic wr, input logic sel, input logic st,
                       input logic rd, input logic [7:0] d);
        @(negedge clk);
        ui_in  = d;
        uio_in = {4'($urandom), rd, st, sel, wr};
        @(posedge clk);
        model_step(wr, sel, st, rd, d);
    endtask

    task automatic load(input logic [127:0] k, input logic [127:0] p);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, blk_byte(k, i));
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, blk_byte(p, i));
    endtask

    task automatic wait_done(input string nm, input int elapsed);
        int  n;
        bit  seen;
        n    = elapsed;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            n++;
            #1;
            seen = uio_out[5];
        end
        chk(nm, 128'(n), 128'd10);
    endtask

    task automatic read_ct(input string nm, input logic [127:0] exp);
        for (int i = 0; i < 16; i++) begin
            chk(nm, 128'(uo_out), 128'(blk_byte(exp, i)));
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            #1;
        end
        chk({nm, "_wrap"}, 128'(uo_out), 128'(blk_byte(exp, 0)));
    endtask

    // Every-cycle comparison of all outputs against the interface model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("uo_out", 128'(uo_out), 128'(blk_byte(m_ct, m_ridx)));
            chk("busy", 128'(uio_out[4]), 128'(m_busy));
            chk("done", 128'(uio_out[5]), 128'(m_done));
            chk("uio_out_zero_bits", 128'({uio_out[7:6], uio_out[3:0]}), 128'h0);
            chk("uio_oe", 128'(uio_oe), 128'hf0);
        end
    end

    initial begin
        logic [7:0] inv;
        logic [127:0] rk, rp;
        int k;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (bmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        chk("model_appB", aes_enc(B_KEY, B_PT), B_CT);
        chk("model_C1", aes_enc(C_KEY, C_PT), C_CT);
        chk("model_zero", aes_enc(128'h0, 128'h0), Z_CT);

        ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00; rst_n = 1'b0;
        model_reset();
        #12;
        chk("reset_uo_out", 128'(uo_out), 128'h0);
        chk("reset_uio_out", 128'(uio_out), 128'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // All-zero key and plaintext straight out of reset.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        wait_done("lat_zero", 0);
        read_ct("ct_zero", Z_CT);

        // App. B with start/wr/rd hammered during busy, then a plain re-start.
        load(B_KEY, B_PT);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom), 1'b1, 1'b1, 8'($urandom));
        wait_done("lat_appB", 5);
        read_ct("ct_appB", B_CT);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        wait_done("lat_restart", 0);
        read_ct("ct_restart", B_CT);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'haa);
        #1;
        chk("done_clear_by_wr", 128'(uio_out[5]), 128'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        wait_done("lat_modkey", 0);

        // C.1 with read-pointer wrap.
        load(C_KEY, C_PT);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        wait_done("lat_C1", 0);
        read_ct("ct_C1", C_CT);

        // Reset while round 5 is in flight.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", 128'(uio_out[4]), 128'h0);
        chk("midrst_done", 128'(uio_out[5]), 128'h0);
        chk("midrst_uo_out", 128'(uo_out), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        load(B_KEY, B_PT);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        wait_done("lat_after_rst", 0);
        read_ct("ct_after_rst", B_CT);

        // Random data, interleaved reads, optional wr+start collision, busy noise.
        for (int it = 0; it < 6; it++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 16; i++) begin
                cyc(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 3) == 0), blk_byte(rk, i));
                if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
            end
            for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, 1'b0, 1'($urandom), blk_byte(rp, i));
            cyc(1'b1, 1'b1, 1'($urandom), 1'b0, blk_byte(rp, 15));
            if (!m_busy) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            k = $urandom_range(0, 9);
            for (int i = 0; i < k; i++)
                cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            wait_done("lat_rand", k);
            for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom), 8'h00);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/tt_um_bah_aes_encrypt.md
# tt_um_bah_aes_encrypt

Tiny Tapeout user-project top implementing AES-128 encryption (FIPS-197, encrypt only) behind a byte-serial pin interface. The host loads a 16-byte key and a 16-byte plaintext through `ui_in`, pulses start, and reads back 16 ciphertext bytes on `uo_out`. The iterative core computes one full round per clock.

## Interface
- No parameters.
- Reset is asynchronous and active-low (`rst_n`); one clock (`clk`).
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `ena` input 1: design-selected flag; ignored.
- `ui_in` input 8: data byte for key or plaintext loading.
- `uio_in` input 8, control strobes:
  - [0] `wr`: load byte.
  - [1] `sel`: 0 = key, 1 = plaintext.
  - [2] `start`.
  - [3] `rd`: advance read pointer.
  - [7:4] unused.
- `uo_out` output 8: ciphertext byte at the read pointer.
- `uio_out` output 8, status:
  - [4] `busy`.
  - [5] `done`.
  - [3:0] and [7:6] are 0.
- `uio_oe` output 8: constant 8'hF0.

## Operation
- All strobes are level-sampled on each rising `clk`; each high cycle counts as one event.
- Byte order follows FIPS-197: byte 0 is the first input byte and the most significant byte of the 128-bit value.
- Load:
  - When not busy, `wr` with `sel`=0 writes `ui_in` to `key[kidx]` and increments `kidx`.
  - When not busy, `wr` with `sel`=1 writes `ui_in` to `pt[pidx]` and increments `pidx`.
  - `kidx` and `pidx` are independent 4-bit counters that wrap 15→0. A 17th byte overwrites byte 0.
  - Any accepted `wr` clears `done`.
- Start:
  - `start` while idle sets `state = pt ^ key`, `rk = key`, `round = 1`, `busy = 1`, `done = 0`.
  - Start also resets `kidx` and `pidx` to 0.
  - `start` while busy is ignored.
- Round r (1..10):
  - Compute `rk_next` from `rk` with Rcon[r]: 01,02,04,08,10,20,40,80,1B,36.
  - Rounds 1–9: `state ← MixColumns(ShiftRows(SubBytes(state))) ^ rk_next`.
  - Round 10: no MixColumns.
- Completion:
  - After round 10, `ct ← state`, `busy = 0`, `done = 1`, `ridx = 0`.
- Read:
  - `uo_out = ct[ridx]` combinationally from registers.
  - `rd` increments `ridx`, which wraps 15→0.
  - `rd` while busy is ignored.
- The `key` and `pt` registers are never modified by encryption. Back-to-back starts re-encrypt the same data.
- `wr` and `start` in the same idle cycle: the byte is written and start samples the pre-write registers.
- Reset, including mid-encryption, clears all of the following to 0: `key`, `pt`, `state`, `rk`, `ct`, all indices, `busy`, `done`, `round`. Consequently `uo_out` = 0 and `uio_out` = 0.

## Timing
- Start is sampled at edge N.
- `busy` is high after edges N through N+9.
- Rounds execute at edges N+1 through N+10.
- Ciphertext is valid and `done` = 1 immediately after edge N+10. Latency is 10 cycles from the start edge.
- The first ciphertext byte is available on `uo_out` with no extra read cycle. Each `rd` pulse exposes the next byte after that edge.
- Critical path is one round: SubBytes → MixColumns → XOR in parallel with key expansion. The design is sized for a TT clock of ≤ 10 MHz.

## Structure
- Shared package `aes_pkg`:
  - Rcon table.
  - `xtime` function.
  - 128-bit block and byte-array typedefs.
  - Index width constant (4).
- Sub-module `aes_sbox`: combinational 8→8 forward S-box, composite-field GF((2^4)^2) inversion plus affine transform (no 256-entry table).
- Instances: 16 `aes_sbox` for state, 4 for key schedule (RotWord/SubWord).
- Round logic and control live in the top; control is a 2-state FSM, IDLE/BUSY, with a 4-bit round counter.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32. `done` is observed exactly 10 cycles after start.
- FIPS-197 C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a. Read all 16 bytes, then a 17th `rd` returns 69 (wrap).
- All-zero key and plaintext (reset state, start without loading) → ct 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Asserting `start` and `wr` during `busy` → ignored; result still matches App. B, and the `key`/`pt` registers are unchanged.
- Reset asserted mid-encryption (round 5) → `busy` = 0, `done` = 0, `uo_out` = 00 immediately. A subsequent reload plus start gives the correct ct.
- Re-start without reloading → same ct; a `wr` after completion clears `done`.
